enc_ptv_walker: RTL and testbench

//  Sequential physical-to-virtual encoder; inverse of the per-stage VTP decode chain.

---
 rtl/qpl_pkg.sv | 26 ++
 rtl/enc_node.sv | 11 +
 rtl/enc_ptv_walker.sv | 115 +++++++++++
 tb/tb_enc_ptv_walker.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/qpl_pkg.sv
// Shared definitions for the page-tracking encoder/decoder blocks: encoder
// state encoding plus index helpers for the stage-major SCB array.
package qpl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } enc_state_e;

  // Width of a down-counter that must hold the values stages-1 down to 0.
  function automatic int stage_cnt_w(input int stages);
    return (stages <= 2) ? 1 : $clog2(stages);
  endfunction

  // Node of stage s that covers a page is the page index with s+1 low bits dropped.
  function automatic int node_index(input int paddr, input int stage);
    return paddr >> (stage + 1);
  endfunction

  // Base bit of stage s inside the flattened SCB array.
  function automatic int scb_stage_offset(input int stage, input int nodes);
    return stage * nodes;
  endfunction

endpackage

// File: rtl/enc_node.sv
// One tree-node step of the physical-to-virtual walk: a set SCB bit swaps
// the two children, so the virtual bit is the physical bit flipped by it.
module enc_node (
  input  logic i_scb_bit,
  input  logic i_pbit,
  output logic o_vbit
);

  assign o_vbit = i_pbit ^ i_scb_bit;

endmodule

// File: rtl/enc_ptv_walker.sv
// Sequential physical-to-virtual page encoder: walks the SCB buddy tree from
// root to leaf, one stage per cycle. Optional stale detection: QPL_ENC_STALE_CHK_EN.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high; a source holding valid keeps its payload stable until that edge.
module enc_ptv_walker
  import qpl_pkg::*;
#(
  parameter int BITMAP = 128
) (
  input  logic                                            i_clk,
  input  logic                                            i_rstn,
  input  logic [$clog2(BITMAP)*(BITMAP/2)-1:0]            i_scb,
  input  logic                                            i_scb_wr,
  input  logic                                            i_valid,
  output logic                                            o_ready,
  input  logic [$clog2(BITMAP)-1:0]                       i_paddr,
  output logic                                            o_valid,
  input  logic                                            i_ready,
  output logic [$clog2(BITMAP)-1:0]                       o_vaddr,
  output logic                                            o_stale,
  output logic [1:0]                                      o_state
);

  localparam int STAGES = $clog2(BITMAP);
  localparam int NODES  = BITMAP / 2;
  localparam int ADDR_W = $clog2(BITMAP);
  localparam int CNT_W  = stage_cnt_w(STAGES);
  localparam int IDX_W  = $clog2(STAGES * NODES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAGES - 1);

  enc_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [ADDR_W-1:0] vaddr_q;
  logic [IDX_W-1:0]  scb_idx;
  logic [CNT_W-1:0]  vbit_idx;
  logic              scb_bit;
  logic              vbit;
  logic              accept;

  assign accept   = (state_q == IDLE) && i_valid;
  // SCB bits are read live so the walk follows the tree as it is right now.
  assign scb_idx  = IDX_W'(scb_stage_offset(int'(cnt_q), NODES)
                         + node_index(int'(paddr_q), int'(cnt_q)));
  assign scb_bit  = i_scb[scb_idx];
  assign vbit_idx = CNT_LAST - cnt_q;

  enc_node u_node (
    .i_scb_bit (scb_bit),
    .i_pbit    (paddr_q[cnt_q]),
    .o_vbit    (vbit)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    o_ready = 1'b0;
    o_valid = 1'b0;
    case (state_q)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_d = WALK;
      end
      WALK: begin
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt_q   <= CNT_LAST;
      paddr_q <= '0;
      vaddr_q <= '0;
    end else if (accept) begin
      cnt_q   <= CNT_LAST;
      paddr_q <= i_paddr;
      vaddr_q <= '0;
    end else if (state_q == WALK) begin
      // Root stage lands in the virtual MSB side's mirror: stage s fills bit STAGES-1-s.
      vaddr_q[vbit_idx] <= vbit;
      cnt_q             <= (cnt_q == '0) ? CNT_LAST : cnt_q - CNT_W'(1);
    end
  end

`ifdef QPL_ENC_STALE_CHK_EN
  logic stale_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)                             stale_q <= 1'b0;
    else if (accept)                         stale_q <= i_scb_wr;
    else if ((state_q == WALK) && i_scb_wr)  stale_q <= 1'b1;
  end

  assign o_stale = stale_q;
`else
  logic unused_scb_wr;
  assign unused_scb_wr = i_scb_wr;
  assign o_stale       = 1'b0;
`endif

  assign o_vaddr = vaddr_q;
  assign o_state = state_q;

endmodule

// File: tb/tb_enc_ptv_walker.sv
// Directed bench for enc_ptv_walker at BITMAP=8: reset values, literal vectors,
// latency, backpressure, chained requests, mid-walk reset and SCB round-trip.
module tb_enc_ptv_walker;

  localparam int BITMAP = 8;
  localparam int STAGES = 3;
  localparam int NODES  = 4;
`ifdef QPL_ENC_STALE_CHK_EN
  localparam bit STALE_EN = 1'b1;
`else
  localparam bit STALE_EN = 1'b0;
`endif

  logic        i_clk;
  logic        i_rstn;
  logic [11:0] i_scb;
  logic        i_scb_wr;
  logic        i_valid;
  logic        o_ready;
  logic [2:0]  i_paddr;
  logic        o_valid;
  logic        i_ready;
  logic [2:0]  o_vaddr;
  logic        o_stale;
  logic [1:0]  o_state;

  int n_checks;
  int n_fail;

  logic [2:0] exp_q[$];
  logic       exp_stale_q[$];
  logic [2:0] exp_pa_q[$];

  enc_ptv_walker #(.BITMAP(BITMAP)) dut (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .i_scb    (i_scb),
    .i_scb_wr (i_scb_wr),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_paddr  (i_paddr),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_vaddr  (o_vaddr),
    .o_stale  (o_stale),
    .o_state  (o_state)
  );

  // ---------------- clock / reset ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- model ----------------
  // Tree semantics: at each stage the SCB bit of the covering node swaps children.
  function automatic logic [2:0] model_encode(input logic [2:0] pa, input logic [11:0] scb);
    logic [2:0] v;
    v = '0;
    for (int s = 0; s < STAGES; s++)
      v[STAGES-1-s] = pa[s] ^ scb[s*NODES + (int'(pa) >> (s+1))];
    return v;
  endfunction

  // Independent decoder (VTP direction): rebuild paddr root-first from vaddr.
  function automatic logic [2:0] model_decode(input logic [2:0] va, input logic [11:0] scb);
    int p;
    p = 0;
    for (int s = STAGES-1; s >= 0; s--) begin
      int k;
      k = p >> (s+1);
      p = p | (int'(va[STAGES-1-s] ^ scb[s*NODES + k]) << s);
    end
    return 3'(p);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard compare ----------------
  initial begin
    logic [2:0] e;
    logic       es;
    logic [2:0] ep;
    forever begin
      @(negedge i_clk);
      #2;
      if (i_rstn && o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: got %0h expected no result", o_vaddr);
        end else begin
          e  = exp_q.pop_front();
          es = exp_stale_q.pop_front();
          ep = exp_pa_q.pop_front();
          check("sb_vaddr", 32'(o_vaddr), 32'(e));
          check("sb_stale", 32'(o_stale), 32'(es));
          check("sb_roundtrip", 32'(model_decode(o_vaddr, i_scb)), 32'(ep));
        end
      end
    end
  end

  // ---------------- driver ----------------
  // wr_at: -1 none, 0 accept cycle, 1..3 walk cycle index.
  task automatic run_req(input logic [2:0] pa, input int hold, input int wr_at,
                         input bit chain, input logic [2:0] next_pa,
                         output logic [2:0] got);
    int         edges;
    int         n;
    logic [2:0] held;
    n = 0;
    while (!o_ready && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    check("ready_before_req", 32'(o_ready), 32'd1);
    exp_q.push_back(model_encode(pa, i_scb));
    exp_stale_q.push_back(STALE_EN && (wr_at >= 0) && (wr_at <= 3));
    exp_pa_q.push_back(pa);
    i_valid  = 1'b1;
    i_paddr  = pa;
    i_ready  = 1'b0;
    i_scb_wr = (wr_at == 0);
    edges    = 0;
    do begin
      @(negedge i_clk);
      edges++;
      i_valid  = 1'b0;
      i_paddr  = ~pa;
      i_scb_wr = (edges == wr_at);
      if (edges == 1) check("walk_ready_low", 32'(o_ready), 32'd0);
    end while (!o_valid && edges < 20);
    i_scb_wr = 1'b0;
    check("latency_edges", 32'(edges), 32'(STAGES + 1));
    got  = o_vaddr;
    held = o_vaddr;
    for (int i = 0; i < hold; i++) begin
      i_valid = 1'b1;
      i_paddr = 3'($urandom_range(0, 7));
      @(negedge i_clk);
      check("bp_valid", 32'(o_valid), 32'd1);
      check("bp_vaddr", 32'(o_vaddr), 32'(held));
      check("bp_ready", 32'(o_ready), 32'd0);
    end
    i_valid = chain;
    i_paddr = next_pa;
    i_ready = 1'b1;
    @(negedge i_clk);
    i_ready = 1'b0;
    check("post_valid_low", 32'(o_valid), 32'd0);
    if (chain) check("chain_idle_ready", 32'(o_ready), 32'd1);
    else       i_valid = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [2:0] got;
    n_checks = 0;
    n_fail   = 0;
    i_rstn   = 1'b0;
    i_scb    = '0;
    i_scb_wr = 1'b0;
    i_valid  = 1'b0;
    i_paddr  = '0;
    i_ready  = 1'b0;
    repeat (3) @(negedge i_clk);
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_vaddr", 32'(o_vaddr), 32'd0);
    check("rst_stale", 32'(o_stale), 32'd0);
    i_rstn = 1'b1;
    @(negedge i_clk);

    // All-zero tree: pure bit reversal.
    i_scb = 12'h000;
    run_req(3'b001, 0, -1, 1'b0, 3'b000, got);
    check("lit_allzero", 32'(got), 32'h4);
    run_req(3'b110, 0, -1, 1'b0, 3'b000, got);
    check("lit_allzero_rev", 32'(got), 32'h3);

    // Root swap only.
    i_scb = 12'h100;
    run_req(3'b001, 0, -1, 1'b0, 3'b000, got);
    check("lit_root", 32'(got), 32'h5);

    // Stage-1 node-1 swap with 5 cycles of backpressure.
    i_scb = 12'h020;
    run_req(3'b110, 5, -1, 1'b0, 3'b000, got);
    check("lit_mid_bp", 32'(got), 32'h1);

    // Result handshake with a new request waiting; it is taken next cycle.
    i_scb = 12'h5a3;
    run_req(3'b101, 1, -1, 1'b1, 3'b010, got);
    run_req(3'b010, 0, -1, 1'b0, 3'b000, got);

    // Stale flag: write in walk, clean walk, write in accept cycle.
    i_scb = 12'h3c6;
    run_req(3'b011, 0, 2, 1'b0, 3'b000, got);
    run_req(3'b011, 0, -1, 1'b0, 3'b000, got);
    run_req(3'b100, 0, 0, 1'b0, 3'b000, got);

    // Reset in the middle of a walk.
    i_valid = 1'b1;
    i_paddr = 3'b111;
    @(negedge i_clk);
    i_valid = 1'b0;
    @(negedge i_clk);
    #1 i_rstn = 1'b0;
    #1;
    check("midrst_ready", 32'(o_ready), 32'd1);
    check("midrst_valid", 32'(o_valid), 32'd0);
    check("midrst_vaddr", 32'(o_vaddr), 32'd0);
    check("midrst_stale", 32'(o_stale), 32'd0);
    @(negedge i_clk);
    i_rstn = 1'b1;
    @(negedge i_clk);
    i_scb = 12'h000;
    run_req(3'b011, 0, -1, 1'b0, 3'b000, got);
    check("lit_after_rst", 32'(got), 32'h6);

    // Round trip over every page with random trees.
    for (int p = 0; p < BITMAP; p++) begin
      i_scb = 12'($urandom);
      run_req(3'(p), $urandom_range(0, 2), -1, 1'b0, 3'b000, got);
    end

    repeat (2) @(negedge i_clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
